// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//   Definitions shared by the caches, the arbiter and the main-memory
//   responder: the request/response field widths, the line burst length and
//   the responder FSM state encoding.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int MEM_ADDR_BITS   = 28;   // word address width
    localparam int MEM_DATA_BITS   = 128;  // beat width
    localparam int MEM_TAG_BITS    = 5;    // request/response tag width
    localparam int MEM_DATA_CYCLES = 4;    // beats per cache line
    localparam int MEM_MASK_BITS   = MEM_DATA_BITS / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // waiting for a request
        WDATA = 2'd1,  // consuming write beats
        RWAIT = 2'd2,  // read accepted, counting down the latency
        RRESP = 2'd3   // streaming read beats
    } mem_state_e;

endpackage

// File: rtl/mem_responder_ram.sv
// -----------------------------------------------------------------------------
// mem_responder_ram
//   Single-port, byte-masked storage of 2^DEPTH_BITS words of MEM_DATA_BITS.
//   Reads are synchronous: the word addressed in cycle N appears on rdata in
//   cycle N+1 and then holds until the next read.
//
// Ports
//   clk    in   clock
//   reset  in   asynchronous active-high reset (read register only)
//   en     in   access enable
//   we     in   1 = write, 0 = read (when en)
//   addr   in   word address
//   wdata  in   write data
//   wmask  in   byte enables for a write, bit i covers byte i
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module mem_responder_ram
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_BITS = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     we,
    input  logic [DEPTH_BITS-1:0]    addr,
    input  logic [MEM_DATA_BITS-1:0] wdata,
    input  logic [MEM_MASK_BITS-1:0] wmask,
    output logic [MEM_DATA_BITS-1:0] rdata
);

    localparam int WORDS = 1 << DEPTH_BITS;

    logic [MEM_DATA_BITS-1:0] mem [WORDS];

    // NOTE: the storage array sits in its own clocked block with no reset so it
    // maps onto block RAM; clearing a memory on reset would force it into flops.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < MEM_MASK_BITS; b++) begin
                if (wmask[b]) begin
                    // NOTE: clocked state always uses non-blocking assignment so
                    // every register samples its inputs from before the edge.
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // The read register is ordinary control-visible state, so it is cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Target side of the main-memory request/response protocol. Accepts one
//   tagged line request at a time from the arbiter. Writes consume
//   MEM_DATA_CYCLES byte-masked beats; reads return MEM_DATA_CYCLES contiguous
//   beats starting LATENCY cycles after acceptance, tagged with the request tag.
//   Address bits above DEPTH_BITS-1 are ignored and bursts wrap at the top of
//   storage.
//
// Parameters
//   DEPTH_BITS  log2 of storage words
//   LATENCY     cycles from read acceptance to first beat, legal range 2..15
//
// Ports
//   clk                 in   clock
//   reset               in   asynchronous active-high reset
//   mem_req_valid       in   request valid
//   mem_req_ready       out  request accepted when valid & ready
//   mem_req_rw          in   1 = write, 0 = read
//   mem_req_addr        in   base word address
//   mem_req_tag         in   request tag
//   mem_req_data_valid  in   write beat valid
//   mem_req_data_ready  out  write beat accepted when valid & ready
//   mem_req_data_bits   in   write beat data
//   mem_req_data_mask   in   write byte enables
//   mem_resp_valid      out  read beat valid (no backpressure)
//   mem_resp_data       out  read beat data, holds when not valid
//   mem_resp_tag        out  tag of the originating read, holds when not valid
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_BITS = 12,
    parameter int LATENCY    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    output logic                     mem_req_ready,
    input  logic                     mem_req_rw,
    input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    input  logic [MEM_TAG_BITS-1:0]  mem_req_tag,
    input  logic                     mem_req_data_valid,
    output logic                     mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
    input  logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
    output logic                     mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0] mem_resp_data,
    output logic [MEM_TAG_BITS-1:0]  mem_resp_tag
);

    localparam int BEAT_BITS = $clog2(MEM_DATA_CYCLES + 1);
    localparam int LAT_BITS  = 4;

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(MEM_DATA_CYCLES - 1);
    localparam logic [BEAT_BITS-1:0] ALL_BEATS = BEAT_BITS'(MEM_DATA_CYCLES);
    // The RAM adds one cycle, so beat 0 is read one cycle before it is shown.
    localparam logic [LAT_BITS-1:0]  ISSUE_AT  = LAT_BITS'(LATENCY - 1);

    mem_state_e                state_q, state_d;
    logic [BEAT_BITS-1:0]      beat_q, beat_d;     // beats written / reads issued
    logic [LAT_BITS-1:0]       lat_q, lat_d;       // cycles since read acceptance
    logic [DEPTH_BITS-1:0]     base_q, base_d;     // latched base word
    logic [MEM_TAG_BITS-1:0]   tag_q, tag_d;       // latched request tag
    logic                      req_ready_q;
    logic                      resp_valid_q;
    logic [MEM_TAG_BITS-1:0]   resp_tag_q;

    logic                      ram_en;
    logic                      ram_we;
    logic [DEPTH_BITS-1:0]     ram_addr;
    logic                      rd_issue;

    // Upper address bits select nothing in a memory of this depth.
    if (MEM_ADDR_BITS > DEPTH_BITS) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^mem_req_addr[MEM_ADDR_BITS-1:DEPTH_BITS];
    end

    // Beat i always targets base+i; the add wraps naturally at the top.
    assign ram_addr = base_q + DEPTH_BITS'(beat_q);
    assign rd_issue = ram_en && !ram_we;

    // Next state, counters and the write-side handshake.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        state_d            = state_q;
        beat_d             = beat_q;
        lat_d              = lat_q;
        base_d             = base_q;
        tag_d              = tag_q;
        ram_en             = 1'b0;
        ram_we             = 1'b0;
        mem_req_data_ready = 1'b0;

        case (state_q)
            IDLE: begin
                // The direction is captured by the state we move to.
                if (mem_req_valid && req_ready_q) begin
                    base_d  = mem_req_addr[DEPTH_BITS-1:0];
                    tag_d   = mem_req_tag;
                    beat_d  = '0;
                    lat_d   = '0;
                    state_d = mem_req_rw ? WDATA : RWAIT;
                end
            end

            WDATA: begin
                mem_req_data_ready = 1'b1;
                if (mem_req_data_valid) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end

            RWAIT: begin
                if (lat_q == ISSUE_AT) begin
                    ram_en  = 1'b1;          // read of beat 0
                    beat_d  = BEAT_BITS'(1);
                    lat_d   = '0;
                    state_d = RRESP;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            RRESP: begin
                // Reads run one cycle ahead of the beats on the bus; once all
                // are issued this is the cycle the final beat is presented.
                if (beat_q == ALL_BEATS) begin
                    beat_d  = '0;
                    state_d = IDLE;
                end else begin
                    ram_en = 1'b1;
                    beat_d = beat_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            lat_q        <= '0;
            base_q       <= '0;
            tag_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            lat_q        <= lat_d;
            base_q       <= base_d;
            tag_q        <= tag_d;
            // Registered so ready stays low through reset and rises on the
            // first edge afterwards.
            req_ready_q  <= (state_d == IDLE);
            // A read issued this cycle is on the bus next cycle.
            resp_valid_q <= rd_issue;
            if (rd_issue) begin
                resp_tag_q <= tag_q;
            end
        end
    end

    mem_responder_ram #(
        .DEPTH_BITS (DEPTH_BITS)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (mem_req_data_bits),
        .wmask (mem_req_data_mask),
        .rdata (mem_resp_data)
    );

    assign mem_req_ready  = req_ready_q;
    assign mem_resp_valid = resp_valid_q;
    assign mem_resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder. A word/byte-level memory model
//   tracks every committed write beat; read bursts are checked for exact cycle
//   timing, data and tag against that model.
// -----------------------------------------------------------------------------
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int DEPTH_BITS = 12;
    localparam int LATENCY    = 4;
    localparam int DEPTH      = 1 << DEPTH_BITS;
    localparam int AW         = MEM_ADDR_BITS;
    localparam int DW         = MEM_DATA_BITS;
    localparam int TW         = MEM_TAG_BITS;
    localparam int MW         = MEM_MASK_BITS;
    localparam int NB         = MEM_DATA_CYCLES;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_req_valid = 1'b0;
    logic          mem_req_ready;
    logic          mem_req_rw = 1'b0;
    logic [AW-1:0] mem_req_addr = '0;
    logic [TW-1:0] mem_req_tag = '0;
    logic          mem_req_data_valid = 1'b0;
    logic          mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits = '0;
    logic [MW-1:0] mem_req_data_mask = '0;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic [TW-1:0] mem_resp_tag;

    int errors = 0;
    int checks = 0;

    // Reference memory: contents plus which bytes have ever been written.
    logic [DW-1:0] model_mem [DEPTH];
    logic [MW-1:0] known     [DEPTH];

    // Beats and masks for the next write request.
    logic [DW-1:0] wbeat [NB];
    logic [MW-1:0] wmask [NB];

    mem_responder #(
        .DEPTH_BITS (DEPTH_BITS),
        .LATENCY    (LATENCY)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data),
        .mem_resp_tag       (mem_resp_tag)
    );

    always #5 clk = ~clk;

    // Word touched by beat i of a burst at addr: upper bits ignored, wraps.
    function automatic int word_of(input logic [AW-1:0] addr, input int i);
        return int'((32'(addr) + 32'(i)) % 32'(DEPTH));
    endfunction

    function automatic logic [DW-1:0] byte_expand(input logic [MW-1:0] m);
        logic [DW-1:0] r;
        for (int b = 0; b < MW; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    function automatic void model_write(input logic [AW-1:0] addr, input int i,
                                        input logic [DW-1:0] d, input logic [MW-1:0] m);
        int w;
        w = word_of(addr, i);
        for (int b = 0; b < MW; b++) begin
            if (m[b]) begin
                model_mem[w][b*8 +: 8] = d[b*8 +: 8];
                known[w][b] = 1'b1;
            end
        end
    endfunction

    // All stimulus tasks start and end just after a falling edge.

    // Write request with NB beats from wbeat/wmask. gap_mode: 0 = no gaps,
    // 1 = valid every other cycle, 2 = random gaps. With hold_read a read
    // request is kept asserted during the data phase and left pending.
    task automatic do_write(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                            input int gap_mode, input bit hold_read,
                            input logic [AW-1:0] raddr, input logic [TW-1:0] rtag);
        int beat;
        int cyc;
        beat = 0;
        cyc  = 0;
        checks++;
        if (mem_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_req_ready: got %b expected 1", mem_req_ready);
        end
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = addr;
        mem_req_tag        = tag;
        // Stray beat in the acceptance cycle; it must not be taken.
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = ~wbeat[0];
        mem_req_data_mask  = '1;
        @(posedge clk);
        @(negedge clk);
        if (hold_read) begin
            mem_req_rw   = 1'b0;
            mem_req_addr = raddr;
            mem_req_tag  = rtag;
        end else begin
            mem_req_valid = 1'b0;
        end
        while (beat < NB && cyc < 64) begin
            checks++;
            if (mem_req_data_ready !== 1'b1) begin
                errors++;
                $display("FAIL write_data_ready beat %0d: got %b expected 1", beat, mem_req_data_ready);
            end
            checks++;
            if (mem_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL req_ready_during_write beat %0d: got %b expected 0", beat, mem_req_ready);
            end
            case (gap_mode)
                0:       mem_req_data_valid = 1'b1;
                1:       mem_req_data_valid = (cyc % 2 == 1);
                default: mem_req_data_valid = ($urandom_range(0, 2) != 0);
            endcase
            mem_req_data_bits = wbeat[beat];
            mem_req_data_mask = wmask[beat];
            @(posedge clk);
            if (mem_req_data_valid) begin
                model_write(addr, beat, wbeat[beat], wmask[beat]);
                beat++;
            end
            @(negedge clk);
            cyc++;
        end
        mem_req_data_valid = 1'b0;
        checks++;
        if (beat != NB) begin
            errors++;
            $display("FAIL write_timeout: got %0d beats expected %0d", beat, NB);
        end
        checks++;
        if (mem_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_after_write: got %b expected 1", mem_req_ready);
        end
        checks++;
        if (mem_req_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL data_ready_after_write: got %b expected 0", mem_req_data_ready);
        end
    endtask

    // A read request is being driven now; check acceptance and the burst.
    task automatic finish_read(input logic [AW-1:0] addr, input logic [TW-1:0] tag);
        int            w;
        logic [DW-1:0] km;
        logic          exp_valid;
        logic          exp_ready;
        checks++;
        if (mem_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_req_ready: got %b expected 1", mem_req_ready);
        end
        @(posedge clk);               // acceptance edge T
        @(negedge clk);               // cycle T
        mem_req_valid = 1'b0;
        for (int k = 0; k <= LATENCY + NB; k++) begin
            exp_valid = (k >= LATENCY) && (k < LATENCY + NB);
            exp_ready = (k == LATENCY + NB);
            checks++;
            if (mem_resp_valid !== exp_valid) begin
                errors++;
                $display("FAIL resp_valid cycle T+%0d: got %b expected %b", k, mem_resp_valid, exp_valid);
            end
            checks++;
            if (mem_req_ready !== exp_ready) begin
                errors++;
                $display("FAIL req_ready_during_read cycle T+%0d: got %b expected %b", k, mem_req_ready, exp_ready);
            end
            if (exp_valid) begin
                w  = word_of(addr, k - LATENCY);
                km = byte_expand(known[w]);
                checks++;
                if ((mem_resp_data & km) !== (model_mem[w] & km)) begin
                    errors++;
                    $display("FAIL resp_data beat %0d word %0d: got %h expected %h",
                             k - LATENCY, w, mem_resp_data & km, model_mem[w] & km);
                end
                checks++;
                if (mem_resp_tag !== tag) begin
                    errors++;
                    $display("FAIL resp_tag beat %0d: got %0d expected %0d", k - LATENCY, mem_resp_tag, tag);
                end
            end
            if (k < LATENCY + NB) @(negedge clk);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [TW-1:0] tag);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        finish_read(addr, tag);
    endtask

    // Asynchronous reset pulse starting mid-cycle.
    task automatic pulse_reset(input string name);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s resp_valid_in_reset: got %b expected 0", name, mem_resp_valid);
        end
        checks++;
        if (mem_req_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s data_ready_in_reset: got %b expected 0", name, mem_req_data_ready);
        end
        checks++;
        if (mem_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s req_ready_in_reset: got %b expected 0", name, mem_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready_after_reset: got %b expected 1", name, mem_req_ready);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 0", mem_req_ready);
        end
        checks++;
        if (mem_resp_valid !== 1'b0 || mem_req_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: got resp_valid=%b data_ready=%b expected 0/0",
                     mem_resp_valid, mem_req_data_ready);
        end
        checks++;
        if (mem_resp_data !== '0 || mem_resp_tag !== '0) begin
            errors++;
            $display("FAIL reset_resp_fields: got data=%h tag=%0d expected 0/0", mem_resp_data, mem_resp_tag);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_req_ready: got %b expected 1", mem_req_ready);
        end
        checks++;
        if (mem_resp_valid !== 1'b0 || mem_req_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_valids: got resp_valid=%b data_ready=%b expected 0/0",
                     mem_resp_valid, mem_req_data_ready);
        end
    endtask

    task automatic test_write_read();
        for (int b = 0; b < NB; b++) begin
            wbeat[b] = DW'(8'hA0 + b);
            wmask[b] = '1;
        end
        do_write(AW'('h10), TW'(3), 0, 1'b0, '0, '0);
        do_read(AW'('h10), TW'(7));
    endtask

    task automatic test_partial_mask();
        for (int b = 0; b < NB; b++) begin
            wbeat[b] = '1;
            wmask[b] = '1;
        end
        do_write(AW'('h20), TW'(1), 0, 1'b0, '0, '0);
        for (int b = 0; b < NB; b++) begin
            wbeat[b] = '0;
            wmask[b] = '0;
        end
        wmask[0] = MW'(1);
        do_write(AW'('h20), TW'(2), 0, 1'b0, '0, '0);
        do_read(AW'('h20), TW'(4));
    endtask

    task automatic test_backpressure();
        for (int b = 0; b < NB; b++) begin
            wbeat[b] = {$urandom, $urandom, $urandom, $urandom};
            wmask[b] = '1;
        end
        do_write(AW'('h40), TW'(9), 1, 1'b1, AW'('h40), TW'(22));
        finish_read(AW'('h40), TW'(22));
        // Back-to-back read straight after the burst.
        do_read(AW'('h40), TW'(23));
    endtask

    task automatic test_wrap();
        for (int b = 0; b < NB; b++) begin
            wbeat[b] = DW'(8'h50 + b);
            wmask[b] = '1;
        end
        do_write(AW'(0), TW'(10), 0, 1'b0, '0, '0);
        for (int b = 0; b < NB; b++) wbeat[b] = DW'(8'hE0 + b);
        do_write(AW'('h3A5_0FFE), TW'(11), 2, 1'b0, '0, '0);
        do_read(AW'(0), TW'(12));
        do_read(AW'('h000_0FFE), TW'(13));
    endtask

    task automatic test_mid_reset();
        for (int b = 0; b < NB; b++) begin
            wbeat[b] = DW'(8'hC0 + b);
            wmask[b] = '1;
        end
        do_write(AW'('h80), TW'(1), 0, 1'b0, '0, '0);
        // Write aborted after two committed beats.
        for (int b = 0; b < NB; b++) wbeat[b] = DW'(8'hD0 + b);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = AW'('h80);
        mem_req_tag   = TW'(2);
        @(posedge clk);
        @(negedge clk);
        mem_req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_req_data_valid = 1'b1;
            mem_req_data_bits  = wbeat[i];
            mem_req_data_mask  = '1;
            @(posedge clk);
            model_write(AW'('h80), i, wbeat[i], '1);
            @(negedge clk);
        end
        mem_req_data_valid = 1'b0;
        pulse_reset("write_abort");
        do_read(AW'('h80), TW'(4));
        // Read aborted while beat 1 is on the bus.
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = AW'('h80);
        mem_req_tag   = TW'(5);
        @(posedge clk);
        @(negedge clk);
        mem_req_valid = 1'b0;
        repeat (LATENCY + 1) @(negedge clk);
        checks++;
        if (mem_resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_beat1_valid: got %b expected 1", mem_resp_valid);
        end
        pulse_reset("read_abort");
        for (int k = 0; k < LATENCY + 2 * NB; k++) begin
            checks++;
            if (mem_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL beat_after_abort cycle %0d: got %b expected 0", k, mem_resp_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int it = 0; it < 16; it++) begin
            a = AW'($urandom);
            for (int b = 0; b < NB; b++) begin
                wbeat[b] = {$urandom, $urandom, $urandom, $urandom};
                wmask[b] = '1;
            end
            do_write(a, TW'($urandom), 2, 1'b0, '0, '0);
            if (it % 2 == 1) begin
                for (int b = 0; b < NB; b++) begin
                    wbeat[b] = {$urandom, $urandom, $urandom, $urandom};
                    wmask[b] = MW'($urandom);
                end
                do_write(a, TW'($urandom), 2, 1'b0, '0, '0);
            end
            // Read accepted the cycle after the write completes.
            do_read(a, TW'($urandom));
        end
    endtask

    initial begin
        for (int w = 0; w < DEPTH; w++) begin
            model_mem[w] = '0;
            known[w]     = '0;
        end
        test_reset();
        test_write_read();
        test_partial_mask();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
